binary_clock_core: RTL and testbench
====================================

// Module: binary_clock_core
// PURPOSE
//  Time-of-day core, 12-hour format. Divides clk_100MHz down to a 1 Hz timebase and keeps seconds/minutes/hours/AM-PM.
//  Applies debounced set buttons. Drives tick_1Hz and end_of_day into the downstream calendar block.
//  Provides binary and BCD time outputs to the display mux.
// PARAMETERS
//  DIV      100_000_000  clk cycles per second; benches override (e.g. 10)
//  SYNC_FF  3            synchroniser depth for button inputs (>=2)
// PORTS
//  clk_100MHz  in   1  system clock, 100 MHz
//  reset       in   1  asynchronous, active-high
//  inc_hour    in   1  raw button: hour +1
//  inc_min     in   1  raw button: minute +1
//  clr_sec     in   1  raw button: seconds and prescaler to 0
//  tick_1Hz    out  1  1 Hz square wave, registered
//  end_of_day  out  1  high for the whole 11:59:59 PM second, registered
//  tick_en     out  1  1-cycle pulse on each second advance
//  hours       out  4  1..12
//  minutes     out  6  0..59
//  seconds     out  6  0..59
//  am_or_pm    out  1  0=AM, 1=PM
//  h_10s,h_1s,m_10s,m_1s,s_10s,s_1s  out  4 each  BCD of hours/minutes/seconds
// BEHAVIOUR
//  Reset: time 12:00:00 AM, am_or_pm=0, prescaler=0, tick_1Hz=0, end_of_day=0, tick_en=0, pending flags=0.
//  Reset is honoured mid-second. Synchroniser FFs also clear.
//  Prescaler: counts 0..DIV-1 and wraps. Counter width is $clog2(DIV).
//  tick_en=1 in the cycle prescaler==DIV-1. Time fields update on that same clock edge.
//  tick_1Hz: 0 while prescaler<DIV/2, 1 otherwise. Rising edge sits mid-second.
//   This gives end_of_day and all time fields DIV/2 cycles of setup before the calendar samples them.
//  Second advance: sec 59->0 carries into min; min 59->0 carries into hour.
//  Hour sequence: 12->1, 1..10 ->+1, 11->12.
//  am_or_pm toggles on every 11->12 hour transition, whether from carry or from inc_hour.
//  end_of_day = (hours==11 && minutes==59 && seconds==59 && am_or_pm). Registered: updates on the same edge as the fields.
//  Consequence: the calendar day rolls at the mid-point of 11:59:59 PM.
//  Buttons: SYNC_FF-stage synchroniser, then rising-edge detect. Each edge sets a pending flag.
//  A pending flag is serviced in the first cycle with tick_en=0, then cleared.
//   A tick always wins, so no second is ever lost. Latency is edge detect + 0..1 cycles.
//  Several pending flags may be serviced in the same cycle, in the order clr_sec, then inc_min, then inc_hour.
//  inc_min: minute +1, 59->0, no carry into hours.
//  inc_hour: hour step as above, including the AM/PM toggle.
//  clr_sec: seconds=0 and prescaler=0 (tick_1Hz drops to 0). Minutes are not affected.
//  A held button gives exactly one edge. Auto-repeat is out of scope.
//  BCD: combinational /10 and %10 of the binary registers.
//  Binary fields never leave their legal range. Any illegal value (SEU, X) loads the reset value on the next tick.
// STRUCTURE
//  clock_pkg: DIV default, HOUR_MIN=1, HOUR_MAX=12, MIN_MAX=SEC_MAX=59, reset time constants. Shared with calendar.
//  Sub-module btn_sync_edge (param SYNC_FF; in: clk, reset, btn; out: rise): instantiate 3x.
//  Top level holds the prescaler, time registers, pending flags and BCD conversion. Target about 200 lines.
// TESTING (DIV=10)
//  1. Reset, run 10 cycles -> tick_en exactly once at cycle 9; seconds 0->1; tick_1Hz high during prescaler 5..9.
//  2. Preload to 11:59:58 PM, run 2 s -> end_of_day high for exactly 10 cycles (the 11:59:59 second);
//     then 12:00:00 AM, am_or_pm=0.
//  3. Preload to 11:59:59 AM, one tick -> 12:00:00, am_or_pm=1, end_of_day stays 0; 12:59:59 -> 1:00:00.
//  4. Pulse inc_min in the cycle before a tick -> minute +1 applied in the cycle after tick_en.
//     Seconds still advance; 59->0 does not change hours.
//  5. clr_sec at prescaler=7, seconds=30 -> seconds=0, prescaler=0, tick_1Hz=0, next tick_en 10 cycles later.
//  6. Assert reset mid-second at 5:17:42 PM -> all outputs at reset values immediately, without a clock edge.
//     Time resumes from 12:00:00 AM after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day types, limits and step functions for the clock core.
// The calendar block imports the same package.
package clock_pkg;

    localparam int unsigned DIV_DEFAULT = 100_000_000;

    localparam logic [3:0] HOUR_MIN     = 4'd1;
    localparam logic [3:0] HOUR_MAX     = 4'd12;
    localparam logic [3:0] HOUR_PM_FLIP = 4'd11;
    localparam logic [5:0] MIN_MAX      = 6'd59;
    localparam logic [5:0] SEC_MAX      = 6'd59;

    typedef struct packed {
        logic       am_or_pm;
        logic [3:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
    } time_t;

    typedef struct packed {
        logic hour;
        logic minute;
        logic clr;
    } pend_t;

    localparam time_t RESET_TIME = '{am_or_pm: 1'b0, hours: HOUR_MAX,
                                     minutes: 6'd0, seconds: 6'd0};

    function automatic logic time_legal(input time_t t);
        return (t.hours >= HOUR_MIN) && (t.hours <= HOUR_MAX) &&
               (t.minutes <= MIN_MAX) && (t.seconds <= SEC_MAX);
    endfunction

    // 12 -> 1, 11 -> 12 flips AM/PM, everything else +1.
    function automatic time_t step_hour(input time_t t);
        time_t n;
        n = t;
        if (t.hours == HOUR_MAX) begin
            n.hours = HOUR_MIN;
        end else begin
            n.hours = t.hours + 4'd1;
            if (t.hours == HOUR_PM_FLIP) begin
                n.am_or_pm = ~t.am_or_pm;
            end
        end
        return n;
    endfunction

    function automatic time_t step_minute(input time_t t);
        time_t n;
        n = t;
        n.minutes = (t.minutes == MIN_MAX) ? 6'd0 : t.minutes + 6'd1;
        return n;
    endfunction

    function automatic time_t advance_second(input time_t t);
        time_t n;
        n = t;
        if (t.seconds == SEC_MAX) begin
            n.seconds = 6'd0;
            if (t.minutes == MIN_MAX) begin
                n.minutes = 6'd0;
                n = step_hour(n);
            end else begin
                n.minutes = t.minutes + 6'd1;
            end
        end else begin
            n.seconds = t.seconds + 6'd1;
        end
        return n;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Raw button synchroniser followed by a rising-edge detector.
// rise is high for one cycle per press; a held button yields a single edge.
module btn_sync_edge #(
    parameter int unsigned SYNC_FF = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic [SYNC_FF-1:0] sync_q, sync_d;
    logic               last_q, last_d;

    always_comb begin
        sync_d = {sync_q[SYNC_FF-2:0], btn};
        last_d = sync_q[SYNC_FF-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign rise = sync_q[SYNC_FF-1] & ~last_q;

endmodule

// File: rtl/binary_clock_core.sv
// 12-hour time-of-day core: 1 Hz prescaler, time registers, set buttons,
// calendar hand-off signals and BCD outputs for the display mux.
module binary_clock_core
    import clock_pkg::*;
#(
    parameter int unsigned DIV     = DIV_DEFAULT,
    parameter int unsigned SYNC_FF = 3
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       clr_sec,
    output logic       tick_1Hz,
    output logic       end_of_day,
    output logic       tick_en,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       am_or_pm,
    output logic [3:0] h_10s,
    output logic [3:0] h_1s,
    output logic [3:0] m_10s,
    output logic [3:0] m_1s,
    output logic [3:0] s_10s,
    output logic [3:0] s_1s
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(DIV / 2);

    logic [PW-1:0] presc_q, presc_d;
    time_t         time_q, time_d;
    pend_t         pend_q, pend_d;
    logic          tick_1hz_q, tick_1hz_d;
    logic          eod_q, eod_d;
    logic          tick;
    logic          rise_hour, rise_min, rise_clr;

    btn_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync_hour (
        .clk   (clk_100MHz),
        .reset (reset),
        .btn   (inc_hour),
        .rise  (rise_hour)
    );

    btn_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync_min (
        .clk   (clk_100MHz),
        .reset (reset),
        .btn   (inc_min),
        .rise  (rise_min)
    );

    btn_sync_edge #(.SYNC_FF(SYNC_FF)) u_sync_clr (
        .clk   (clk_100MHz),
        .reset (reset),
        .btn   (clr_sec),
        .rise  (rise_clr)
    );

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = (presc_q >= PRESC_LAST) ? '0 : presc_q + PW'(1);
        time_d  = time_q;
        pend_d  = pend_q;

        // A tick owns the cycle; pending buttons wait one cycle so no second is lost.
        if (tick) begin
            time_d = time_legal(time_q) ? advance_second(time_q) : RESET_TIME;
        end else begin
            if (pend_q.clr) begin
                time_d.seconds = 6'd0;
                presc_d        = '0;
            end
            if (pend_q.minute) begin
                time_d = step_minute(time_d);
            end
            if (pend_q.hour) begin
                time_d = step_hour(time_d);
            end
            pend_d = '0;
        end

        pend_d.clr    = pend_d.clr    | rise_clr;
        pend_d.minute = pend_d.minute | rise_min;
        pend_d.hour   = pend_d.hour   | rise_hour;

        tick_1hz_d = (presc_d >= PRESC_HALF);
        eod_d      = (time_d.hours == HOUR_PM_FLIP) && (time_d.minutes == MIN_MAX) &&
                     (time_d.seconds == SEC_MAX) && time_d.am_or_pm;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            time_q     <= RESET_TIME;
            pend_q     <= '0;
            tick_1hz_q <= 1'b0;
            eod_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            time_q     <= time_d;
            pend_q     <= pend_d;
            tick_1hz_q <= tick_1hz_d;
            eod_q      <= eod_d;
        end
    end

    assign tick_en    = tick;
    assign tick_1Hz   = tick_1hz_q;
    assign end_of_day = eod_q;
    assign hours      = time_q.hours;
    assign minutes    = time_q.minutes;
    assign seconds    = time_q.seconds;
    assign am_or_pm   = time_q.am_or_pm;

    assign {h_10s, h_1s} = to_bcd({2'b00, time_q.hours});
    assign {m_10s, m_1s} = to_bcd(time_q.minutes);
    assign {s_10s, s_1s} = to_bcd(time_q.seconds);

endmodule

// File: tb/tb_binary_clock_core.sv
// Bench for binary_clock_core with DIV=10: time is set through the buttons,
// expected times are queued as stimulus is driven and compared as the DUT updates.
module tb_binary_clock_core;

    localparam int DIV = 10;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       inc_hour   = 1'b0;
    logic       inc_min    = 1'b0;
    logic       clr_sec    = 1'b0;
    logic       tick_1Hz, end_of_day, tick_en, am_or_pm;
    logic [3:0] hours, h_10s, h_1s, m_10s, m_1s, s_10s, s_1s;
    logic [5:0] minutes, seconds;

    binary_clock_core #(.DIV(DIV), .SYNC_FF(3)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .clr_sec    (clr_sec),
        .tick_1Hz   (tick_1Hz),
        .end_of_day (end_of_day),
        .tick_en    (tick_en),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .am_or_pm   (am_or_pm),
        .h_10s      (h_10s),
        .h_1s       (h_1s),
        .m_10s      (m_10s),
        .m_1s       (m_1s),
        .s_10s      (s_10s),
        .s_1s       (s_1s)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    typedef struct packed {
        logic       pm;
        logic [3:0] h;
        logic [5:0] mi;
        logic [5:0] s;
    } tm_t;

    localparam tm_t T_RST = '{pm: 1'b0, h: 4'd12, mi: 6'd0, s: 6'd0};

    tm_t         m;
    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [16:0] dut_t;
    logic [23:0] dut_bcd;

    assign dut_t   = {am_or_pm, hours, minutes, seconds};
    assign dut_bcd = {h_10s, h_1s, m_10s, m_1s, s_10s, s_1s};

    function automatic tm_t hour_step(input tm_t t);
        tm_t n = t;
        if (t.h == 4'd12) n.h = 4'd1;
        else begin
            n.h = t.h + 4'd1;
            if (t.h == 4'd11) n.pm = ~t.pm;
        end
        return n;
    endfunction

    function automatic tm_t min_step(input tm_t t);
        tm_t n = t;
        n.mi = (t.mi == 6'd59) ? 6'd0 : t.mi + 6'd1;
        return n;
    endfunction

    function automatic tm_t adv_sec(input tm_t t);
        tm_t n = t;
        if (t.s != 6'd59) n.s = t.s + 6'd1;
        else begin
            n.s = 6'd0;
            if (t.mi != 6'd59) n.mi = t.mi + 6'd1;
            else begin
                n.mi = 6'd0;
                n = hour_step(n);
            end
        end
        return n;
    endfunction

    function automatic logic [23:0] bcd_of(input tm_t t);
        return {4'(t.h / 4'd10), 4'(t.h % 4'd10), 4'(t.mi / 6'd10), 4'(t.mi % 6'd10),
                4'(t.s / 6'd10), 4'(t.s % 6'd10)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        tm_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(1), 32'(0));
        end else begin
            e = tm_t'(exp_q.pop_front());
            check(tag, 32'(dut_t), 32'(e));
            check({tag, "_bcd"}, 32'(dut_bcd), 32'(bcd_of(e)));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_tick();
        int n = 0;
        while (tick_en !== 1'b1 && n < 2 * DIV) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (tick_en !== 1'b1) check("tick_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_second();
        m = adv_sec(m);
        exp_q.push_back(m);
        wait_tick();
        @(negedge clk_100MHz);
        pop_check("second");
    endtask

    // Called right after a tick; the effect lands well before the next tick.
    task automatic press(input int kind);
        string tg;
        case (kind)
            0:       begin clr_sec  = 1'b1; m.s = 6'd0;       tg = "clr_sec";  end
            1:       begin inc_min  = 1'b1; m = min_step(m);  tg = "inc_min";  end
            default: begin inc_hour = 1'b1; m = hour_step(m); tg = "inc_hour"; end
        endcase
        exp_q.push_back(m);
        repeat (6) @(negedge clk_100MHz);
        clr_sec  = 1'b0;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
        pop_check(tg);
    endtask

    task automatic keep_sec_low();
        if (m.s >= 6'd50) begin
            press(0);
            run_second();
        end
    endtask

    task automatic set_hour(input logic [3:0] h, input logic pm);
        while (!(m.h == h && m.pm == pm)) begin
            keep_sec_low();
            press(2);
            run_second();
        end
    endtask

    task automatic set_min(input logic [5:0] mi);
        while (m.mi != mi) begin
            keep_sec_low();
            press(1);
            run_second();
        end
    endtask

    task automatic set_sec(input logic [5:0] s);
        press(0);
        while (m.s != s) run_second();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_time"}, 32'(dut_t), 32'(T_RST));
        check({tag, "_bcd"}, 32'(dut_bcd), 32'(bcd_of(T_RST)));
        check({tag, "_tick_1Hz"}, 32'(tick_1Hz), 32'(0));
        check({tag, "_end_of_day"}, 32'(end_of_day), 32'(0));
        check({tag, "_tick_en"}, 32'(tick_en), 32'(0));
    endtask

    // ---------------- sequence ----------------
    initial begin
        int   n;
        int   eod_cnt;
        int   ntick;
        tm_t  e1;

        #12;
        check_reset_outputs("reset");
        @(negedge clk_100MHz);
        reset = 1'b0;
        m = T_RST;

        // first second: tick_en once at prescaler 9, square wave high for 5..9
        for (int c = 0; c < DIV; c++) begin
            check($sformatf("t1_tick_en_c%0d", c), 32'(tick_en), 32'(c == DIV - 1));
            check($sformatf("t1_tick_1Hz_c%0d", c), 32'(tick_1Hz), 32'(c >= DIV / 2));
            check($sformatf("t1_seconds_c%0d", c), 32'(seconds), 32'(0));
            @(negedge clk_100MHz);
        end
        m = adv_sec(m);
        exp_q.push_back(m);
        pop_check("t1_first_second");

        // 11:59:59 AM -> 12:00:00 PM
        set_hour(4'd11, 1'b0);
        set_min(6'd59);
        set_sec(6'd59);
        check("t3_eod_am", 32'(end_of_day), 32'(0));
        run_second();
        check("t3_am_or_pm", 32'(am_or_pm), 32'(1));
        check("t3_eod_after", 32'(end_of_day), 32'(0));

        // 12:59:59 PM -> 1:00:00 PM
        set_min(6'd59);
        set_sec(6'd59);
        run_second();
        check("t3_hour_one", 32'(hours), 32'(1));

        // manual minute 59 -> 0 leaves hours alone
        set_min(6'd59);
        keep_sec_low();
        press(1);
        run_second();
        check("t4_min_wrap_hours", 32'(hours), 32'(1));

        // inc_min edge colliding with a tick is applied the cycle after
        keep_sec_low();
        repeat (5) @(negedge clk_100MHz);
        inc_min = 1'b1;
        e1 = adv_sec(m);
        m  = min_step(e1);
        exp_q.push_back(e1);
        exp_q.push_back(m);
        repeat (4) @(negedge clk_100MHz);
        check("t4_tick_en", 32'(tick_en), 32'(1));
        @(negedge clk_100MHz);
        pop_check("t4_tick_first");
        @(negedge clk_100MHz);
        pop_check("t4_min_after_tick");
        inc_min = 1'b0;
        run_second();

        // 11:59:58 PM: end_of_day covers exactly the 11:59:59 PM second
        set_hour(4'd11, 1'b1);
        set_min(6'd59);
        set_sec(6'd58);
        check("t2_eod_before", 32'(end_of_day), 32'(0));
        eod_cnt = 0;
        ntick   = 0;
        m = adv_sec(adv_sec(m));
        exp_q.push_back(m);
        repeat (2 * DIV) begin
            @(negedge clk_100MHz);
            if (end_of_day === 1'b1) eod_cnt++;
            if (tick_en === 1'b1) ntick++;
        end
        pop_check("t2_midnight");
        check("t2_eod_cycles", 32'(eod_cnt), 32'(DIV));
        check("t2_ticks", 32'(ntick), 32'(2));
        check("t2_am_or_pm", 32'(am_or_pm), 32'(0));

        // clr_sec serviced at prescaler 7 with seconds at 30
        set_sec(6'd30);
        repeat (3) @(negedge clk_100MHz);
        clr_sec = 1'b1;
        m.s = 6'd0;
        exp_q.push_back(m);
        repeat (4) @(negedge clk_100MHz);
        check("t5_tick_1Hz_before", 32'(tick_1Hz), 32'(1));
        check("t5_seconds_before", 32'(seconds), 32'(30));
        @(negedge clk_100MHz);
        pop_check("t5_cleared");
        check("t5_tick_1Hz_after", 32'(tick_1Hz), 32'(0));
        clr_sec = 1'b0;
        n = 0;
        while (tick_en !== 1'b1 && n < 2 * DIV) begin
            @(negedge clk_100MHz);
            n++;
        end
        check("t5_tick_gap", 32'(n + 1), 32'(DIV));
        m = adv_sec(m);
        exp_q.push_back(m);
        @(negedge clk_100MHz);
        pop_check("t5_next_second");

        // asynchronous reset mid-second at 5:17:42 PM
        set_hour(4'd5, 1'b1);
        set_min(6'd17);
        set_sec(6'd42);
        repeat (7) @(negedge clk_100MHz);
        check("t6_tick_1Hz_before", 32'(tick_1Hz), 32'(1));
        check("t6_time_before", 32'(dut_t), 32'({1'b1, 4'd5, 6'd17, 6'd42}));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        exp_q.delete();
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b0;
        m = T_RST;
        run_second();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
